// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter with a registered one-hot grant, owner release, and a hold-time limit.
// Between two grants there is always at least one idle cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; the next winner is chosen from req, starting after last
// GRANT | grant held for owner own_q; hold_q counts the cycles held
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int LW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] own_q, own_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic [LW-1:0] win;
  logic [LW-1:0] cand;
  logic          found;
  logic          rel_done, rel_drop, rel_lim;

  // Search starts one past the previous owner and wraps modulo N.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = LW'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign rel_done = done;
  assign rel_drop = ~req[own_q];
  assign rel_lim  = (hold_q == HW'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    own_d     = own_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          own_d        = win;
          hold_d       = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_lim) begin
          grant_d   = '0;
          last_d    = own_q;
          hold_d    = '0;
          state_d   = IDLE;
          // Only a pure counter expiry counts as a forced release.
          timeout_d = rel_lim & ~rel_done & ~rel_drop;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= LW'(N - 1);
      own_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      own_q     <= own_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign gnt_valid = |grant_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios, then random traffic, all checked
// against a cycle-level reference model of owner, last winner, and cycles held.
module tb_rr_arbiter_8;

  localparam int N        = 8;
  localparam int HOLD_MAX = 15;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         gnt_valid;
  logic         timeout;

  int n_cmp;
  int n_mis;

  // Reference model state.
  int   m_owner;
  int   m_last;
  int   m_held;
  logic m_to;

  rr_arbiter_8 #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    int  c;
    bit  by_done, by_drop, by_lim;
    if (m_owner < 0) begin
      m_to = 1'b0;
      c = pick(r, m_last);
      if (c >= 0) begin
        m_owner = c;
        m_held  = 1;
      end
    end else begin
      by_done = d;
      by_drop = !r[m_owner];
      by_lim  = (m_held == HOLD_MAX);
      if (by_done || by_drop || by_lim) begin
        m_last  = m_owner;
        m_owner = -1;
        m_held  = 0;
        m_to    = by_lim && !by_done && !by_drop;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_g;
    exp_g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    chk("grant", grant, exp_g);
    chk("gnt_valid", {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
    chk("timeout", {7'b0, timeout}, {7'b0, m_to});
    chk("inv_onehot0", {7'b0, $onehot0(grant)}, 8'h01);
    chk("inv_valid", {7'b0, gnt_valid}, {7'b0, (grant != 8'h00)});
    chk("inv_to_idle", {7'b0, (timeout && (grant != 8'h00))}, 8'h00);
  endtask

  // Inputs change just after the falling edge; outputs checked 1 time unit after the rising edge.
  task automatic tick(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    if (rst_n) model_edge(r, d);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       d;
    n_cmp = 0;
    n_mis = 0;
    model_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;

    // 1: reset with all requests pending; channel 0 wins first.
    #1;
    check_all();
    @(negedge clk);
    repeat (3) tick(8'hFF, 1'b0);
    rst_n = 1'b1;
    tick(8'hFF, 1'b0);
    chk("t1_first_grant", grant, 8'h01);

    // 2: done after each grant rotates through every channel.
    for (int k = 0; k < 9; k++) begin
      tick(8'hFF, 1'b1);
      chk("t2_dead_cycle", grant, 8'h00);
      tick(8'hFF, 1'b0);
      chk("t2_order", grant, 8'(1 << ((k + 1) % N)));
    end

    // 3: two persistent requesters, released only by the hold limit.
    do_reset();
    tick(8'h24, 1'b0);
    chk("t3_first", grant, 8'h04);
    repeat (HOLD_MAX - 1) tick(8'h24, 1'b0);
    chk("t3_held", grant, 8'h04);
    tick(8'h24, 1'b0);
    chk("t3_timeout", {7'b0, timeout}, 8'h01);
    tick(8'h24, 1'b0);
    chk("t3_second", grant, 8'h20);
    repeat (2 * HOLD_MAX + 4) tick(8'h24, 1'b0);

    // 4: owner drops its request; search resumes after it.
    do_reset();
    tick(8'h08, 1'b0);
    chk("t4_grant08", grant, 8'h08);
    tick(8'h81, 1'b0);
    chk("t4_released", grant, 8'h00);
    chk("t4_no_timeout", {7'b0, timeout}, 8'h00);
    tick(8'h81, 1'b0);
    chk("t4_grant80", grant, 8'h80);

    // 5: reset in the middle of a grant.
    do_reset();
    tick(8'h10, 1'b0);
    chk("t5_grant10", grant, 8'h10);
    tick(8'h10, 1'b0);
    do_reset();
    tick(8'hFF, 1'b0);
    chk("t5_restart", grant, 8'h01);

    // 6: done coincides with the hold limit, then a long idle stretch.
    do_reset();
    repeat (HOLD_MAX) tick(8'h01, 1'b0);
    chk("t6_held", grant, 8'h01);
    tick(8'h01, 1'b1);
    chk("t6_released", grant, 8'h00);
    chk("t6_no_timeout", {7'b0, timeout}, 8'h00);
    repeat (20) tick(8'h00, 1'b0);

    // Random traffic, with persistent request patterns so hold limits are reached.
    r = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      d = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick(r, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
